fft_r22sdf_bf: RTL

Parametrised radix-2² single-delay-feedback butterfly stage. It selects Type I (plain) or Type II (with trivial -j rotation) behaviour by parameter. The stage generates its own sel/rotate control from an internal sample counter. It also adds a sample-enable handshake, frame sync, selectable bit growth or rounded scaling, and saturation. One instance per stage in the streaming FFT pipeline; instances are cascaded directly, valid_o to en_i.

---
 rtl/fft_r22sdf_bf.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fft_r22sdf_bf.sv
// Radix-2^2 single-delay-feedback butterfly stage (BF-I or BF-II).
// The stage derives its own butterfly/rotation control from a sample counter.
// The counter advances only on accepted samples (en_i); sync_i realigns it.
// The output is either full precision (DW+1 bits) or rounded-half-up to DW bits.
module fft_r22sdf_bf #(
   parameter int DW      = 25,
   parameter int FSR_LEN = 4,
   parameter int MODE    = 0,
   parameter int GROW    = 1,
   localparam int OW     = DW + GROW
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 sync_i,
   input  logic signed [DW-1:0] x_re_i,
   input  logic signed [DW-1:0] x_im_i,
   output logic                 valid_o,
   output logic signed [OW-1:0] z_re_o,
   output logic signed [OW-1:0] z_im_o,
   output logic                 sat_o
);

   localparam int LW = $clog2(FSR_LEN);   // bit of k that selects the butterfly half
   localparam int CW = LW + 2;            // counter spans 4*L samples
   localparam int PW = LW + 1;            // priming counter reaches L-1

   localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0] SMAX = ~SMIN;

   // Negation that clamps the single unrepresentable case (-2^(DW-1)).
   function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] a);
      if (a == SMIN) return SMAX;
      return -a;
   endfunction

   // Output formatting: pass through, or (v+1)>>>1 evaluated one bit wider so +1 cannot wrap.
   function automatic logic signed [OW-1:0] fmt_out(input logic signed [DW:0] v);
      logic signed [DW+1:0] t;
      t = {v[DW], v} + (DW+2)'(1);
      if (GROW != 0) return OW'(v);
      return OW'(t >>> 1);
   endfunction

   logic [CW-1:0]        cnt_q, cnt_d;
   logic [PW-1:0]        pcnt_q, pcnt_d;
   logic                 primed_q, primed_d;
   logic                 valid_q, valid_d;
   logic                 sat_q, sat_d;
   logic signed [DW:0]   dl_re_q [FSR_LEN];
   logic signed [DW:0]   dl_im_q [FSR_LEN];
   logic signed [DW:0]   dl_re_d [FSR_LEN];
   logic signed [DW:0]   dl_im_d [FSR_LEN];
   logic signed [OW-1:0] z_re_q, z_re_d, z_im_q, z_im_d;

   logic [CW-1:0]        k;
   logic                 sel, rot;
   logic signed [DW-1:0] xr, xi;
   logic signed [DW:0]   xr_e, xi_e, d_re, d_im, bf_re, bf_im, din_re, din_im;

   // Control decode, -j rotation, butterfly and next-state for every register.
   always_comb begin
      cnt_d    = cnt_q;
      pcnt_d   = pcnt_q;
      primed_d = primed_q;
      sat_d    = sat_q;
      z_re_d   = z_re_q;
      z_im_d   = z_im_q;
      dl_re_d  = dl_re_q;
      dl_im_d  = dl_im_q;
      valid_d  = en_i && primed_q;

      k   = sync_i ? '0 : cnt_q;
      sel = k[LW];
      rot = (MODE != 0) && sel && k[LW+1];

      xr = x_re_i;
      xi = x_im_i;
      if (rot) begin
         xr = x_im_i;
         xi = neg_sat(x_re_i);
      end
      xr_e = {xr[DW-1], xr};
      xi_e = {xi[DW-1], xi};

      d_re = dl_re_q[FSR_LEN-1];
      d_im = dl_im_q[FSR_LEN-1];
      if (sel) begin
         bf_re  = d_re + xr_e;
         bf_im  = d_im + xi_e;
         din_re = d_re - xr_e;
         din_im = d_im - xi_e;
      end else begin
         bf_re  = d_re;
         bf_im  = d_im;
         din_re = xr_e;
         din_im = xi_e;
      end

      if (en_i) begin
         cnt_d  = k + CW'(1);
         z_re_d = fmt_out(bf_re);
         z_im_d = fmt_out(bf_im);
         for (int i = FSR_LEN - 1; i > 0; i--) begin
            dl_re_d[i] = dl_re_q[i-1];
            dl_im_d[i] = dl_im_q[i-1];
         end
         dl_re_d[0] = din_re;
         dl_im_d[0] = din_im;
         if (rot && (x_re_i == SMIN)) sat_d = 1'b1;
         if (!primed_q) begin
            if (pcnt_q == PW'(FSR_LEN - 1)) primed_d = 1'b1;
            else                            pcnt_d   = pcnt_q + PW'(1);
         end
      end
   end

   // State registers; reset clears control, delay line and outputs alike.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         pcnt_q   <= '0;
         primed_q <= 1'b0;
         valid_q  <= 1'b0;
         sat_q    <= 1'b0;
         z_re_q   <= '0;
         z_im_q   <= '0;
         dl_re_q  <= '{default: '0};
         dl_im_q  <= '{default: '0};
      end else begin
         cnt_q    <= cnt_d;
         pcnt_q   <= pcnt_d;
         primed_q <= primed_d;
         valid_q  <= valid_d;
         sat_q    <= sat_d;
         z_re_q   <= z_re_d;
         z_im_q   <= z_im_d;
         dl_re_q  <= dl_re_d;
         dl_im_q  <= dl_im_d;
      end
   end

   assign valid_o = valid_q;
   assign z_re_o  = z_re_q;
   assign z_im_o  = z_im_q;
   assign sat_o   = sat_q;

endmodule
